// File: rtl/ah_snoop_hazard_gate.sv
// rtl/ah_snoop_hazard_gate.sv - read-request gate that holds a request until it no longer hits the write FIFO
// Snoops each accepted key, backs off for RETRY_GAP cycles on every hit, and forwards only hazard-free keys.
module ah_snoop_hazard_gate #(
    parameter int WIDTH     = 164,
    parameter int RETRY_GAP = 4,
    parameter int MAX_RETRY = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] qdata,
    input  logic             qvalid,
    output logic             qready,
    output logic [WIDTH-1:0] sdata,
    output logic             svalid,
    input  logic             smatch,
    output logic [WIDTH-1:0] odata,
    output logic             ovalid,
    input  logic             oready,
    output logic [15:0]      hazard_cnt,
    output logic             stuck,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SNOOP = 2'd1,
        S_WAIT  = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    localparam logic [7:0] GAP_INIT  = 8'(RETRY_GAP);
    localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_req;
    logic [7:0]       r_gap_cnt;
    logic [7:0]       r_retry_cnt;
    logic [15:0]      r_hazard_cnt;
    logic             w_accept;
    logic             w_issue_done;
    logic             w_hit;

    assign qready       = (r_state == S_IDLE) | ((r_state == S_ISSUE) & oready);
    assign svalid       = (r_state == S_SNOOP);
    assign ovalid       = (r_state == S_ISSUE);
    assign sdata        = r_req;
    assign odata        = r_req;
    assign busy         = (r_state != S_IDLE);
    assign stuck        = (r_retry_cnt >= RETRY_LIM);
    assign hazard_cnt   = r_hazard_cnt;

    assign w_accept     = qvalid & qready;
    assign w_issue_done = (r_state == S_ISSUE) & oready;
    // smatch only means something while the snoop strobe is up
    assign w_hit        = (r_state == S_SNOOP) & smatch;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (qvalid)            w_next_state = S_SNOOP;
            S_SNOOP: w_next_state = smatch ? S_WAIT : S_ISSUE;
            S_WAIT:  if (r_gap_cnt <= 8'd1) w_next_state = S_SNOOP;
            S_ISSUE: if (oready)            w_next_state = qvalid ? S_SNOOP : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req        <= '0;
            r_gap_cnt    <= '0;
            r_retry_cnt  <= '0;
            r_hazard_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_req <= qdata;
            end
            if (w_accept || w_issue_done) begin
                r_retry_cnt <= '0;
            end else if (w_hit && (r_retry_cnt != 8'hFF)) begin
                r_retry_cnt <= r_retry_cnt + 8'd1;
            end
            if (w_hit) begin
                r_gap_cnt <= GAP_INIT;
                if (r_hazard_cnt != 16'hFFFF) begin
                    r_hazard_cnt <= r_hazard_cnt + 16'd1;
                end
            end else if (r_state == S_WAIT) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ah_snoop_hazard_gate.sv
// tb/tb_ah_snoop_hazard_gate.sv - bench for ah_snoop_hazard_gate
// Timeline reference model: each request's next snoop cycle is scheduled arithmetically from its accept/hit cycles.
module tb_ah_snoop_hazard_gate;

    localparam int W   = 164;
    localparam int GAP = 4;
    localparam int MR  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] qdata;
    logic         qvalid;
    logic         qready;
    logic [W-1:0] sdata;
    logic         svalid;
    logic         smatch;
    logic [W-1:0] odata;
    logic         ovalid;
    logic         oready;
    logic [15:0]  hazard_cnt;
    logic         stuck;
    logic         busy;

    ah_snoop_hazard_gate #(.WIDTH(W), .RETRY_GAP(GAP), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst),
        .qdata(qdata), .qvalid(qvalid), .qready(qready),
        .sdata(sdata), .svalid(svalid), .smatch(smatch),
        .odata(odata), .ovalid(ovalid), .oready(oready),
        .hazard_cnt(hazard_cnt), .stuck(stuck), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: request in flight, its key, and the cycle of its next snoop
    int           cyc;
    bit           m_busy;
    bit           m_issue;
    int           m_next;
    int           m_hits;
    int           m_hazard;
    logic [W-1:0] m_key;

    // outputs sampled by the last step
    logic         s_qready, s_svalid, s_ovalid, s_stuck, s_busy;
    logic [W-1:0] s_sdata, s_odata;
    logic [15:0]  s_hazard;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_issue = 0; m_next = 0; m_hits = 0; m_hazard = 0; m_key = '0;
    endtask

    task automatic step(input logic r, input logic qv, input logic [W-1:0] qd,
                        input logic ordy, input logic sm);
        bit e_sv, e_qr;
        rst = r; qvalid = qv; qdata = qd; oready = ordy; smatch = sm;
        @(negedge clk);
        e_sv = m_busy && !m_issue && (cyc == m_next);
        e_qr = !m_busy || (m_issue && ordy);
        s_qready = qready; s_svalid = svalid; s_ovalid = ovalid; s_stuck = stuck;
        s_busy = busy; s_sdata = sdata; s_odata = odata; s_hazard = hazard_cnt;
        check("qready", W'(qready), W'(e_qr));
        check("svalid", W'(svalid), W'(e_sv));
        check("ovalid", W'(ovalid), W'(m_issue));
        check("busy", W'(busy), W'(m_busy));
        check("stuck", W'(stuck), W'(m_hits >= MR));
        check("hazard_cnt", W'(hazard_cnt), W'(m_hazard));
        check("sdata", sdata, m_key);
        if (m_issue) check("odata", odata, m_key);
        if (r) begin
            model_reset();
        end else if (e_sv) begin
            if (sm) begin
                if (m_hazard < 65535) m_hazard++;
                if (m_hits < 255) m_hits++;
                m_next = cyc + 1 + GAP;
            end else begin
                m_issue = 1;
            end
        end else if (m_issue) begin
            if (ordy) begin
                m_issue = 0;
                m_hits  = 0;
                if (qv) begin
                    m_key = qd; m_next = cyc + 1;
                end else begin
                    m_busy = 0;
                end
            end
        end else if (!m_busy && qv) begin
            m_busy = 1; m_key = qd; m_hits = 0; m_next = cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_n(input int n, input logic sm);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1, sm);
    endtask

    function automatic logic [W-1:0] rand_key();
        logic [W-1:0] k = '0;
        for (int i = 0; i < 6; i++) k = {k[W-33:0], 32'($urandom())};
        return k;
    endfunction

    initial begin
        cyc = 0;
        rst = 1'b1; qvalid = 1'b0; qdata = '0; oready = 1'b0; smatch = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("rst_qready", W'(s_qready), W'(1));
        check("rst_busy", W'(s_busy), W'(0));

        // no hazard: svalid at N+1, ovalid at N+2
        step(1'b0, 1'b1, W'(5), 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("nh_svalid", W'(s_svalid), W'(1));
        check("nh_sdata", s_sdata, W'(5));
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("nh_ovalid", W'(s_ovalid), W'(1));
        check("nh_odata", s_odata, W'(5));
        check("nh_hazard", W'(s_hazard), W'(0));

        // single hazard: snoops at N+1 and N+6, ovalid at N+7
        step(1'b0, 1'b1, W'(10), 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check("sh_svalid1", W'(s_svalid), W'(1));
        for (int i = 0; i < GAP; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b1);
            check("sh_wait", W'(s_svalid), W'(0));
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("sh_svalid2", W'(s_svalid), W'(1));
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("sh_ovalid", W'(s_ovalid), W'(1));
        check("sh_hazard", W'(s_hazard), W'(1));
        check("sh_stuck", W'(s_stuck), W'(0));

        // stuck: three hits then a miss
        step(1'b0, 1'b1, W'(11), 1'b1, 1'b0);
        for (int h = 0; h < 3; h++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b1);
            step(1'b0, 1'b0, '0, 1'b1, 1'b0);
            if (h >= 1) check("st_stuck_hi", W'(s_stuck), W'(1));
            idle_n(GAP - 1, 1'b0);
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("st_issue", W'(s_ovalid), W'(1));
        check("st_stuck_issue", W'(s_stuck), W'(1));
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("st_stuck_clr", W'(s_stuck), W'(0));
        check("st_hazard", W'(s_hazard), W'(4));

        // backpressure then back-to-back with key 9
        step(1'b0, 1'b1, W'(12), 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, W'(9), 1'b0, 1'b0);
            check("bp_ovalid", W'(s_ovalid), W'(1));
            check("bp_odata", s_odata, W'(12));
            check("bp_qready", W'(s_qready), W'(0));
        end
        step(1'b0, 1'b1, W'(9), 1'b1, 1'b0);
        check("b2b_qready", W'(s_qready), W'(1));
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("b2b_svalid", W'(s_svalid), W'(1));
        check("b2b_sdata", s_sdata, W'(9));
        check("b2b_busy", W'(s_busy), W'(1));
        idle_n(2, 1'b0);

        // reset while in WAIT discards the request
        step(1'b0, 1'b1, W'(13), 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("rw_qready", W'(s_qready), W'(1));
        check("rw_busy", W'(s_busy), W'(0));
        check("rw_hazard", W'(s_hazard), W'(0));
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b0);
            check("rw_no_ovalid", W'(s_ovalid), W'(0));
        end

        // saturation: preload near the top of the hit counter
        force dut.r_hazard_cnt = 16'hFFFD;
        #1;
        release dut.r_hazard_cnt;
        m_hazard = 65533;
        step(1'b0, 1'b1, W'(14), 1'b1, 1'b0);
        for (int h = 0; h < 4; h++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b1);
            idle_n(GAP, 1'b0);
        end
        check("sat_hazard", W'(s_hazard), W'(16'hFFFF));
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), rand_key(),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ah_snoop_hazard_gate.md
# ah_snoop_hazard_gate

Request-ordering stage that sits directly upstream of the snoopable write FIFO's snoop port. Each incoming read request is checked against all entries still held in the FIFO (sdata/svalid → smatch). If there is a hit, the request is held and re-snooped until the conflicting write has drained. Only hazard-free requests are forwarded downstream, so no read can bypass an older pending write to the same key.

## Interface
Parameters:
- WIDTH, 164: request/key width; equals the FIFO data width.
- RETRY_GAP, 4: cycles spent in WAIT between a snoop hit and the next re-snoop; legal range 1..255.
- MAX_RETRY, 16: consecutive hits on one request at which `stuck` asserts; legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- qdata  in  WIDTH  upstream request key.
- qvalid  in  1  upstream request valid.
- qready  out  1  upstream request accept.
- sdata  out  WIDTH  snoop key to FIFO.
- svalid  out  1  snoop strobe to FIFO.
- smatch  in  1  FIFO hit; combinational, valid in the same cycle as svalid.
- odata  out  WIDTH  forwarded request.
- ovalid  out  1  forwarded request valid.
- oready  in  1  downstream accept.
- hazard_cnt  out  16  total snoop hits; saturates at 16'hFFFF.
- stuck  out  1  current request has seen ≥ MAX_RETRY consecutive hits.
- busy  out  1  state != IDLE.

## Operation
- Registers:
  - state: IDLE, SNOOP, WAIT, ISSUE.
  - req_reg: WIDTH bits.
  - gap_cnt: 8 bits.
  - retry_cnt: 8 bits, saturating at 255.
  - hazard_cnt: 16 bits.
- Combinational outputs:
  - qready = (state==IDLE) | (state==ISSUE & oready).
  - svalid = (state==SNOOP); sdata = req_reg at all times.
  - ovalid = (state==ISSUE); odata = req_reg at all times.
  - stuck = (retry_cnt >= MAX_RETRY).
- IDLE: on qvalid (handshake): req_reg←qdata, retry_cnt←0, go to SNOOP.
- SNOOP, smatch=1: hazard_cnt+1 (saturating), retry_cnt+1 (saturating), gap_cnt←RETRY_GAP, go to WAIT.
- SNOOP, smatch=0: go to ISSUE.
- WAIT: gap_cnt decrements each cycle. When gap_cnt==1, go to SNOOP, so exactly RETRY_GAP cycles are spent in WAIT. svalid=0 throughout.
- ISSUE, oready=1 and qvalid=1: back-to-back. req_reg←qdata, retry_cnt←0, go to SNOOP.
- ISSUE, oready=1 and qvalid=0: go to IDLE; retry_cnt←0.
- ISSUE, oready=0: hold. odata stays stable and ovalid stays high; ovalid never drops without a handshake.
- No request is dropped, reordered or duplicated. Exactly one ovalid&oready handshake occurs per qvalid&qready handshake.
- A hit result is never cached: every snoop re-evaluates against the FIFO's live contents.

## Timing
- Reset: rst=1 sampled at an edge forces the following values from the next cycle:
  - state=IDLE; req_reg, gap_cnt, retry_cnt and hazard_cnt all 0.
  - Resulting outputs: qready=1, svalid=0, ovalid=0, sdata=odata=0, hazard_cnt=0, stuck=0, busy=0.
- Reset mid-operation: any held request is discarded without ovalid. rst takes priority over every transition.
- Latency, no hazard: request accepted at edge N → svalid high in cycle N+1 → ovalid high in cycle N+2.
- Each hit adds 1 + RETRY_GAP cycles. With k hits, ovalid is first high in cycle N+2+k·(1+RETRY_GAP).
- Throughput: one request per 2 cycles at best, via the ISSUE→SNOOP back-to-back path.
- smatch is sampled only while svalid=1; it is ignored in every other state.
- Saturation:
  - hazard_cnt holds at FFFF.
  - retry_cnt holds at 255, so stuck stays high until the request issues.
- stuck is advisory only: it does not change flow control. The request keeps retrying until there is no hit or reset.

## Test plan
- **No hazard:** smatch tied 0; send key 0x5 at edge N. Expect svalid=1 with sdata=0x5 in cycle N+1; ovalid=1 with odata=0x5 in cycle N+2; hazard_cnt=0.
- **Single hazard:** RETRY_GAP=4; smatch=1 on the first snoop only. Expect svalid in cycles N+1 and N+6; ovalid in cycle N+7; hazard_cnt=1; stuck=0.
- **Stuck:** MAX_RETRY=2; smatch=1 on 3 snoops, then 0. Expect stuck=1 after the 2nd hit; cleared the cycle after the ISSUE handshake; hazard_cnt=3.
- **Backpressure and back-to-back:** oready=0 for 5 cycles during ISSUE. Expect odata/ovalid stable and qready=0. Then oready=1 with qvalid=1 and key 0x9: the next state is SNOOP with sdata=0x9, and there is no IDLE bubble.
- **Reset mid-WAIT:** assert rst for one cycle while in WAIT. Expect the next cycle to show qready=1, busy=0, hazard_cnt=0, and no ovalid for the discarded key.
- **Saturation:** preload 65535 hits. Expect a further hit to leave hazard_cnt=16'hFFFF.
